// File: rtl/nibble_serial_compare_if.sv
// Operand/result bundle for the nibble-serial comparator: master drives operands
// and start, slave returns the one-hot {gt,lt,eq} code with busy/done status.
interface nibble_serial_compare_if #(
    parameter int WIDTH = 16
);
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic [2:0]       iData;
    logic [2:0]       oData;
    logic             oBusy;
    logic             oDone;

    modport master (
        output iStart,
        output iData_a,
        output iData_b,
        output iData,
        input  oData,
        input  oBusy,
        input  oDone
    );

    modport slave (
        input  iStart,
        input  iData_a,
        input  iData_b,
        input  iData,
        output oData,
        output oBusy,
        output oDone
    );
endinterface

// File: rtl/nibble_serial_compare.sv
// Serial magnitude compare, one nibble per cycle MSB first; 1..NIB cycles after start.
// No backpressure: a start is taken only when idle, starts during a run are dropped.
module nibble_serial_compare #(
    parameter int WIDTH = 16
) (
    input logic                    iClk,
    input logic                    iRst,
    nibble_serial_compare_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int CNTW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [2:0]       cascade;
    logic [2:0]       result;
    logic             busy;
    logic             done;

    logic [3:0]       nibA;
    logic [3:0]       nibB;
    logic [2:0]       cascadeCode;

    // Nibble mux written as a compare loop so non-power-of-two NIB never indexes out of range.
    always_comb begin
        nibA = '0;
        nibB = '0;
        for (int i = 0; i < NIB; i++) begin
            if (cnt == CNTW'(i)) begin
                nibA = opA[4*i +: 4];
                nibB = opB[4*i +: 4];
            end
        end
    end

    // gt wins over lt wins over eq, so a malformed cascade still yields a one-hot code.
    always_comb begin
        cascadeCode = 3'b001;
        if (cascade[2]) begin
            cascadeCode = 3'b100;
        end else if (cascade[1]) begin
            cascadeCode = 3'b010;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            cnt     <= '0;
            opA     <= '0;
            opB     <= '0;
            cascade <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        opA     <= bus.iData_a;
                        opB     <= bus.iData_b;
                        cascade <= bus.iData;
                        cnt     <= CNTW'(NIB - 1);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (nibA > nibB) begin
                        result <= 3'b100;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (nibA < nibB) begin
                        result <= 3'b010;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == '0) begin
                        result <= cascadeCode;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oData = result;
    assign bus.oBusy = busy;
    assign bus.oDone = done;
endmodule

// File: tb/tb_nibble_serial_compare.sv
// Randomized and directed checks of nibble_serial_compare against a whole-word reference model.
module tb_nibble_serial_compare;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst;
    int   nCmp;
    int   nErr;

    nibble_serial_compare_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_compare #(.WIDTH(WIDTH)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected code from whole-word magnitude compare, cascade only on equality.
    function automatic logic [2:0] model_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] c);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        if (c[2]) return 3'b100;
        if (c[1]) return 3'b010;
        return 3'b001;
    endfunction

    // Position (1-based from MSB) of the first differing nibble, NIB if all equal.
    function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int j = 0; j < NIB; j++) begin
            int sh;
            sh = 4 * (NIB - 1 - j);
            if (((a >> sh) & 16'hF) != ((b >> sh) & 16'hF)) return j + 1;
        end
        return NIB;
    endfunction

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] c);
        bus.iData_a = a;
        bus.iData_b = b;
        bus.iData   = c;
        bus.iStart  = 1'b1;
        @(posedge clk);
    endtask

    // Sample e=0 is the negedge right after the accepting edge; lat=-1 means no done seen.
    task automatic wait_done(output int lat, output int busyCnt, output logic busyAtDone);
        lat        = -1;
        busyCnt    = 0;
        busyAtDone = 1'b1;
        for (int e = 0; e <= NIB + 3; e++) begin
            @(negedge clk);
            if (e == 0) bus.iStart = 1'b0;
            if (bus.oDone) begin
                lat        = e;
                busyAtDone = bus.oBusy;
                break;
            end
            if (bus.oBusy) busyCnt++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.iStart  = 1'b1;
        bus.iData_a = 16'h0001;
        bus.iData_b = 16'h0002;
        bus.iData   = 3'b000;
        @(posedge clk);
        @(negedge clk);
        nCmp++; if (bus.oData !== 3'b000) begin nErr++; $display("FAIL reset_data: got %b want 000", bus.oData); end
        nCmp++; if (bus.oBusy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b want 0", bus.oBusy); end
        nCmp++; if (bus.oDone !== 1'b0) begin nErr++; $display("FAIL reset_done: got %b want 0", bus.oDone); end
        bus.iStart = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        nCmp++; if (bus.oBusy !== 1'b0) begin nErr++; $display("FAIL reset_idle_busy: got %b want 0", bus.oBusy); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [6];
        logic [WIDTH-1:0] tb [6];
        logic [2:0]       tc [6];
        logic [2:0]       tr [6];
        int               tl [6];
        int               lat, busyCnt;
        logic             busyAtDone;
        ta = '{16'h1234, 16'h8000, 16'h0F00, 16'hABCD, 16'hABCD, 16'hABCD};
        tb = '{16'h1233, 16'h7FFF, 16'h1000, 16'hABCD, 16'hABCD, 16'hABCD};
        tc = '{3'b000,   3'b000,   3'b000,   3'b010,   3'b000,   3'b110};
        tr = '{3'b100,   3'b100,   3'b010,   3'b010,   3'b001,   3'b100};
        tl = '{4,        1,        1,        4,        4,        4};
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i], tc[i]);
            wait_done(lat, busyCnt, busyAtDone);
            nCmp++; if (lat !== tl[i]) begin nErr++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            nCmp++; if (bus.oData !== tr[i]) begin nErr++; $display("FAIL dir%0d_data: got %b want %b", i, bus.oData, tr[i]); end
            nCmp++; if (busyCnt !== tl[i]) begin nErr++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, busyCnt, tl[i]); end
            nCmp++; if (busyAtDone !== 1'b0) begin nErr++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busyAtDone); end
            @(negedge clk);
            nCmp++; if (bus.oDone !== 1'b0) begin nErr++; $display("FAIL dir%0d_done_width: got %b want 0", i, bus.oDone); end
            nCmp++; if (bus.oData !== tr[i]) begin nErr++; $display("FAIL dir%0d_data_hold: got %b want %b", i, bus.oData, tr[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int dones;
        lat = -1;
        start_op(16'h00F0, 16'h00F1, 3'b000);
        for (int e = 0; e <= NIB + 3; e++) begin
            @(negedge clk);
            bus.iStart = 1'b0;
            if (e == 1) begin
                bus.iStart  = 1'b1;
                bus.iData_a = 16'hFFFF;
                bus.iData_b = 16'h0000;
                bus.iData   = 3'b100;
            end
            if (bus.oDone) begin
                lat = e;
                break;
            end
        end
        bus.iStart = 1'b0;
        nCmp++; if (lat !== 4) begin nErr++; $display("FAIL ignore_latency: got %0d want 4", lat); end
        nCmp++; if (bus.oData !== 3'b010) begin nErr++; $display("FAIL ignore_data: got %b want 010", bus.oData); end
        dones = 0;
        for (int e = 0; e < NIB + 2; e++) begin
            @(negedge clk);
            if (bus.oDone || bus.oBusy) dones++;
        end
        nCmp++; if (dones !== 0) begin nErr++; $display("FAIL ignore_no_queue: got %0d activity cycles want 0", dones); end
    endtask

    task automatic test_abort();
        int dones;
        start_op(16'h5555, 16'h5555, 3'b000);
        @(negedge clk);
        bus.iStart = 1'b0;
        @(negedge clk);
        nCmp++; if (bus.oBusy !== 1'b1) begin nErr++; $display("FAIL abort_busy_before: got %b want 1", bus.oBusy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nCmp++; if (bus.oBusy !== 1'b0) begin nErr++; $display("FAIL abort_busy: got %b want 0", bus.oBusy); end
        nCmp++; if (bus.oData !== 3'b000) begin nErr++; $display("FAIL abort_data: got %b want 000", bus.oData); end
        dones = 0;
        if (bus.oDone) dones++;
        for (int e = 0; e < NIB + 3; e++) begin
            @(negedge clk);
            if (bus.oDone) dones++;
        end
        nCmp++; if (dones !== 0) begin nErr++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int   lat, busyCnt;
        logic busyAtDone;
        start_op(16'h1234, 16'h1234, 3'b000);
        wait_done(lat, busyCnt, busyAtDone);
        nCmp++; if (bus.oData !== 3'b001) begin nErr++; $display("FAIL b2b_first_data: got %b want 001", bus.oData); end
        start_op(16'h0001, 16'h0002, 3'b000);
        wait_done(lat, busyCnt, busyAtDone);
        nCmp++; if (lat !== 4) begin nErr++; $display("FAIL b2b_latency: got %0d want 4", lat); end
        nCmp++; if (bus.oData !== 3'b010) begin nErr++; $display("FAIL b2b_data: got %b want 010", bus.oData); end
        nCmp++; if (busyCnt !== 4) begin nErr++; $display("FAIL b2b_busy_cycles: got %0d want 4", busyCnt); end
        // Result must not clear on start: begin a run and look at the first busy cycle.
        start_op(16'h0000, 16'h0000, 3'b100);
        @(negedge clk);
        bus.iStart = 1'b0;
        nCmp++; if (bus.oData !== 3'b010) begin nErr++; $display("FAIL b2b_hold_on_start: got %b want 010", bus.oData); end
        for (int e = 0; e <= NIB + 2; e++) begin
            if (bus.oDone) break;
            @(negedge clk);
        end
        nCmp++; if (bus.oData !== 3'b100) begin nErr++; $display("FAIL b2b_cascade_gt: got %b want 100", bus.oData); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic [2:0]       c, expData;
        int               expLat, lat, busyCnt, mode;
        logic             busyAtDone;
        for (int i = 0; i < 60; i++) begin
            a    = WIDTH'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       b = WIDTH'($urandom);
                1:       b = a;
                2:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = {a[WIDTH-1:4], 4'($urandom)};
            endcase
            c       = 3'($urandom);
            expData = model_result(a, b, c);
            expLat  = model_latency(a, b);
            start_op(a, b, c);
            wait_done(lat, busyCnt, busyAtDone);
            nCmp++; if (lat !== expLat) begin nErr++; $display("FAIL rand%0d_latency: a=%h b=%h got %0d want %0d", i, a, b, lat, expLat); end
            nCmp++; if (bus.oData !== expData) begin nErr++; $display("FAIL rand%0d_data: a=%h b=%h c=%b got %b want %b", i, a, b, c, bus.oData, expData); end
            nCmp++; if (busyCnt !== expLat) begin nErr++; $display("FAIL rand%0d_busy_cycles: got %0d want %0d", i, busyCnt, expLat); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        nCmp        = 0;
        nErr        = 0;
        rst         = 1'b1;
        bus.iStart  = 1'b0;
        bus.iData_a = '0;
        bus.iData_b = '0;
        bus.iData   = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
